// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction fetch stage.
// Buffer entries pair each instruction with the PC it was fetched from.
package fetch_pkg;

   localparam int INST_W = 32;
   localparam int XLEN   = 64;
   localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Fetch addresses are word aligned; the low two bits of any target are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush; flush beats push in the same cycle.
// The head is read straight from storage, so a push becomes visible one cycle later.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wr_data,
   output fetch_entry_t     rd_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(DEPTH - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // A push into a full buffer is accepted only when a pop frees the slot this cycle.
   always_comb begin
      pop_ok_s  = pop & (count_r != '0);
      push_ok_s = push & ((count_r != CNT_W'(DEPTH)) | pop_ok_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;
   assign empty   = (count_r == '0);
   assign full    = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests and
// buffers returned instructions for decode; execute redirects flush and refetch.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
   parameter int              DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              execute_i_need_jump,
   input  logic [XLEN-1:0]   execute_i_jump_pc,
   output logic              fetch_o_imem_req_valid,
   input  logic              fetch_i_imem_req_ready,
   output logic [XLEN-1:0]   fetch_o_imem_req_addr,
   input  logic              fetch_i_imem_resp_valid,
   input  logic [INST_W-1:0] fetch_i_imem_resp_inst,
   output logic              fetch_o_inst_valid,
   output logic [INST_W-1:0] fetch_o_inst,
   output logic [XLEN-1:0]   fetch_o_pc,
   input  logic              fetch_i_decode_ready
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  req_pc_r;
   logic [XLEN-1:0]  resp_pc_r;
   logic [CNT_W-1:0] inflight_r;
   logic [CNT_W-1:0] drop_cnt_r;
   logic [XLEN-1:0]  jump_tgt_s;
   logic [CNT_W-1:0] count_s;
   logic [CNT_W-1:0] inflight_after_resp_s;
   logic [CNT_W:0]   credit_use_s;
   logic             req_valid_s;
   logic             req_fire_s;
   logic             resp_ok_s;
   logic             push_s;
   logic             pop_s;
   logic             inst_valid_s;
   logic             empty_s;
   logic             full_s;
   fetch_entry_t     push_data_s;
   fetch_entry_t     head_s;

   // Requests are credited against buffer space so a response can never overflow it.
   always_comb begin
      jump_tgt_s            = word_align(execute_i_jump_pc);
      credit_use_s          = {1'b0, inflight_r} + {1'b0, count_s};
      req_valid_s           = rst_n & (credit_use_s < (CNT_W + 1)'(DEPTH)) & ~execute_i_need_jump;
      req_fire_s            = req_valid_s & fetch_i_imem_req_ready;
      resp_ok_s             = fetch_i_imem_resp_valid & (inflight_r != '0);
      push_s                = resp_ok_s & (drop_cnt_r == '0) & ~execute_i_need_jump;
      inst_valid_s          = rst_n & ~empty_s & ~execute_i_need_jump;
      pop_s                 = inst_valid_s & fetch_i_decode_ready;
      inflight_after_resp_s = inflight_r - CNT_W'(resp_ok_s);
      push_data_s           = '{pc: resp_pc_r, inst: fetch_i_imem_resp_inst};
   end

   // PC registers and request/response bookkeeping; a redirect recomputes drop_cnt outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pc_r   <= RESET_PC;
         resp_pc_r  <= RESET_PC;
         inflight_r <= '0;
         drop_cnt_r <= '0;
      end else if (execute_i_need_jump) begin
         req_pc_r   <= jump_tgt_s;
         resp_pc_r  <= jump_tgt_s;
         inflight_r <= inflight_after_resp_s;
         drop_cnt_r <= inflight_after_resp_s;
      end else begin
         if (req_fire_s) begin
            req_pc_r <= req_pc_r + 64'd4;
         end
         if (push_s) begin
            resp_pc_r <= resp_pc_r + 64'd4;
         end
         if (resp_ok_s && (drop_cnt_r != '0)) begin
            drop_cnt_r <= drop_cnt_r - CNT_W'(1);
         end
         inflight_r <= inflight_after_resp_s + CNT_W'(req_fire_s);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .pop     (pop_s),
      .flush   (execute_i_need_jump),
      .wr_data (push_data_s),
      .rd_data (head_s),
      .count   (count_s),
      .empty   (empty_s),
      .full    (full_s)
   );

   assign fetch_o_imem_req_valid = req_valid_s;
   assign fetch_o_imem_req_addr  = req_pc_r;
   assign fetch_o_inst_valid     = inst_valid_s;
   assign fetch_o_inst           = head_s.inst;
   assign fetch_o_pc             = head_s.pc;

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage: it owns the architectural fetch PC, issues in-order word requests to the instruction memory port and buffers returned instructions in a small FIFO for decode. It sits at the front of the pipeline and is the consumer of the execute stage's redirect outputs. Execute drives `need_jump` and `jump_pc` into this block; fetch then flushes and refetches from the new PC, discarding responses that are still in flight.

## Interface
- `RESET_PC`, 64'h0000_0000_8000_0000: first fetch address after reset.
- `DEPTH`, 4: instruction buffer entries, also the cap on in-flight plus buffered requests; legal range 2..8.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `execute_i_need_jump` in 1: redirect strobe from execute, one cycle per redirect.
- `execute_i_jump_pc` in 64: redirect target; bits [1:0] are ignored and treated as 0.
- `fetch_o_imem_req_valid` out 1: request valid.
- `fetch_i_imem_req_ready` in 1: memory accepts the request.
- `fetch_o_imem_req_addr` out 64: word address, bits [1:0] always 0.
- `fetch_i_imem_resp_valid` in 1: response valid; responses return in order and cannot be stalled.
- `fetch_i_imem_resp_inst` in 32: returned instruction.
- `fetch_o_inst_valid` out 1: buffer head valid toward decode.
- `fetch_o_inst` out 32: head instruction.
- `fetch_o_pc` out 64: PC of the head instruction.
- `fetch_i_decode_ready` in 1: decode consumes the head.

## Operation
- State registers:
  - `req_pc`: next address to request.
  - `resp_pc`: PC tag for the next accepted response.
  - `inflight`: requests issued but not yet answered.
  - `drop_cnt`: responses still to be discarded.
  - FIFO of {pc, inst}.
- Counters are `$clog2(DEPTH+1)` bits wide.
- Request rule: `req_valid = (inflight + count < DEPTH) & ~execute_i_need_jump`. A request is only issued when the buffer is guaranteed space, so no response can ever overflow it.
- Request handshake (`valid & ready`):
  - `req_pc += 4`, wrapping modulo 2^64.
  - `inflight += 1`.
- Response when `drop_cnt == 0`:
  - push {`resp_pc`, inst} into the FIFO.
  - `resp_pc += 4`, `inflight -= 1`.
- Response when `drop_cnt != 0`:
  - discard it; `drop_cnt -= 1`, `inflight -= 1`.
- Response while `inflight == 0` is a protocol violation: ignore it, with no counter change.
- Redirect (`execute_i_need_jump = 1`):
  - `req_pc` and `resp_pc` load {jump_pc[63:2], 2'b00}.
  - The FIFO is flushed.
  - `drop_cnt` loads the `inflight` value after this cycle's response has been applied, i.e. the responses still outstanding beyond this cycle.
  - A response arriving in the redirect cycle is discarded.
- Output: `fetch_o_inst_valid = (count != 0) & ~execute_i_need_jump`. A pop occurs on `inst_valid & decode_ready`.
- Simultaneous push and pop with the FIFO full is legal and impossible to overflow because of the credit rule.
- Back-to-back redirects: the second redirect reloads the PCs and recomputes `drop_cnt` from the current `inflight`. It is never summed with the earlier value.

## Timing
- Reset values:
  - `req_pc = resp_pc = RESET_PC`.
  - Counters = 0 and FIFO empty.
  - `fetch_o_inst_valid = 0`, `fetch_o_imem_req_valid = 0` while `rst_n` is low.
  - `fetch_o_imem_req_addr = RESET_PC`; `fetch_o_inst` and `fetch_o_pc` = 0.
- First request: `req_valid` is high in the first cycle after `rst_n` deasserts.
- Response latency: response in cycle N → `inst_valid` in cycle N+1, since the FIFO output is registered and there is no bypass.
- Redirect latency: redirect in cycle N → `req_addr = jump_pc` with `req_valid` high in cycle N+1; `inst_valid` is low in N and stays low until the first fresh response has been pushed.
- Throughput: with 1-cycle memory and decode always ready, one instruction per cycle is sustained for `DEPTH >= 3`.
- Reset asserted mid-operation: all state clears immediately. Memory responses that arrive after reset are the memory's responsibility and must be squashed by the memory side.

## Structure
- `fetch_pkg`:
  - `INST_W = 32`, `XLEN = 64`, default `RESET_PC`.
  - Buffer entry typedef {pc[63:0], inst[31:0]}.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with `push`, `pop`, `flush`, `count`, `empty` and `full`. `flush` has priority over `push` in the same cycle.
- `fetch` holds the PC registers, the `inflight` and `drop_cnt` counters and the request/response control.

## Test plan
- Reset release, memory with 1-cycle latency, decode always ready:
  - requests go out to 0x8000_0000, _0004, _0008, …;
  - `inst_valid` is high from cycle 3 onward;
  - each `fetch_o_pc` matches the address of its request.
- Decode stalled (ready=0) for 10 cycles: `req_valid` drops once `inflight + count = 4`; all 4 instructions then drain in order with no loss.
- Redirect to 0x8000_1002 with 2 requests outstanding:
  - the next request address is 0x8000_1000;
  - both stale responses are discarded;
  - the first delivered instruction has pc 0x8000_1000.
- Redirect in the same cycle as a response, with `inflight = 1`: that response is dropped, `drop_cnt` = 0, and the next response is delivered with pc = `jump_pc`.
- Two redirects in consecutive cycles (0x100, then 0x200): only instructions tagged 0x200, 0x204, … are delivered.
- `rst_n` asserted mid-stream with 3 buffered instructions: outputs clear asynchronously, and after release fetch restarts at `RESET_PC`.
